imem_writer: RTL and testbench
==============================

IMEM_WRITER -- requirements
Module: imem_writer

Interface
REQ-001 Parameter: ADDR_W, 7, byte-address width of the target byte memory (128 bytes).
REQ-002 Parameter: FIFO_DEPTH, 2, number of buffered {address, word} entries.
REQ-003 Port: CLK  input  1  rising-edge clock.
REQ-004 Port: Reset  input  1  asynchronous reset, active-low.
REQ-005 Port: WValid  input  1  request carries a valid word.
REQ-006 Port: WReady  output  1  block can accept a word this cycle.
REQ-007 Port: WAddr  input  32  byte address of the word; only [ADDR_W-1:0] used.
REQ-008 Port: WData  input  32  instruction word.
REQ-009 Port: MemWE  output  1  byte write strobe to the byte memory.
REQ-010 Port: MemAddr  output  ADDR_W  byte address for the current write.
REQ-011 Port: MemByte  output  8  byte data for the current write.
REQ-012 Port: Busy  output  1  FIFO non-empty or a word is being written.
REQ-013 Port: Err  output  1  one-cycle pulse: misaligned word dropped.

Function
REQ-014 Transfer occurs on a rising edge with WValid=1 and WReady=1; the {WAddr[ADDR_W-1:0], WData} pair is pushed into the FIFO.
REQ-015 WReady SHALL be 1 iff FIFO occupancy < FIFO_DEPTH; no same-cycle bypass, so a full FIFO blocks a push even when a pop happens that edge.
REQ-016 FSM states: IDLE, WRITE; IDLE -> WRITE on the edge where the FIFO is non-empty (head popped into working registers, byte counter = 0).
REQ-017 In WRITE, MemWE=1 for exactly 4 consecutive cycles; counter k=0..3 emits MemAddr=A+k, MemByte=WData[31-8k:24-8k] (big-endian, MSB at lowest address).
REQ-018 MemWE, MemAddr, MemByte SHALL be registered outputs; the first MemWE cycle begins 2 edges after the accepting edge.
REQ-019 On the edge ending k=3: if FIFO non-empty, pop next entry and stay in WRITE with k=0 (no gap cycle); otherwise go to IDLE.
REQ-020 Sustained throughput: one word per 4 cycles; with WValid held high, WReady toggles per FIFO occupancy only.
REQ-021 Address arithmetic is modulo 2^ADDR_W: A=7'd126 writes bytes at 126, 127, 0, 1.
REQ-022 In IDLE: MemWE=0; MemAddr and MemByte hold their last values.
REQ-023 Busy = (occupancy != 0) || (state == WRITE), combinational.
REQ-024 Push and pop on the same edge leave occupancy unchanged and preserve entry order.

Reset
REQ-025 Reset low SHALL immediately force state=IDLE, occupancy=0, k=0, MemWE=0, MemAddr=0, MemByte=0, Err=0, WReady=1, Busy=0.
REQ-026 Reset asserted during WRITE aborts the word; remaining bytes are never written and buffered entries are discarded.
REQ-027 The first transfer may occur on the first rising edge after Reset deasserts.

Configuration
REQ-028 Macro IMEM_WR_ALIGN_CHECK_EN defined: a transfer with WAddr[1:0] != 0 completes the handshake but is not pushed, and Err=1 for the one cycle after the accepting edge.
REQ-029 Macro IMEM_WR_ALIGN_CHECK_EN undefined: no alignment check; Err is constant 0; misaligned words are written at A..A+3 per REQ-017/REQ-021.

Verification
REQ-030 Single word: WAddr=0x10, WData=0x8C220004 -> MemWE for 4 cycles, (0x10,0x8C), (0x11,0x22), (0x12,0x00), (0x13,0x04); then IDLE, Busy=0.
REQ-031 Back-to-back: 3 words with WValid held high -> 12 contiguous MemWE cycles, WReady low while 2 entries are buffered, bytes in push order.
REQ-032 Wrap: WAddr=0x7E, WData=0xAABBCCDD -> (0x7E,AA), (0x7F,BB), (0x00,CC), (0x01,DD).
REQ-033 Reset mid-word: Reset low after the second byte, with 1 entry buffered -> MemWE=0 at once, Busy=0, WReady=1, no further writes after release.
REQ-034 Misaligned WAddr=0x05, WData=0x12345678: with IMEM_WR_ALIGN_CHECK_EN -> Err pulse, no MemWE; without it -> bytes 12,34,56,78 written at 0x05..0x08.

Source files
------------

// File: rtl/imem_writer.sv
// imem_writer: buffers {address, word} pairs and writes each word big-endian as four bytes; IMEM_WR_ALIGN_CHECK_EN drops misaligned words with an Err pulse
module imem_writer #(
  parameter int ADDR_W     = 7,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              WValid,
  output logic              WReady,
  input  logic [31:0]       WAddr,
  input  logic [31:0]       WData,
  output logic              MemWE,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [7:0]        MemByte,
  output logic              Busy,
  output logic              Err
);
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] WRITE = 1'b1;
  logic [ADDR_W+31:0] mem [FIFO_DEPTH];
  logic [PW-1:0]      wptr, rptr;
  logic [CW-1:0]      cnt;
  logic [0:0]         state;
  logic [1:0]         k;
  logic [ADDR_W-1:0]  a;
  logic [31:0]        w;
  logic               push, pop, unused_addr;
`ifdef IMEM_WR_ALIGN_CHECK_EN
  assign push = WValid && WReady && WAddr[1:0] == 2'b00;
  // flag a misaligned word accepted and dropped this edge
  always_ff @(posedge CLK or negedge Reset)
    if (!Reset) Err <= 1'b0;
    else Err <= WValid && WReady && WAddr[1:0] != 2'b00;
`else
  assign push = WValid && WReady;
  assign Err  = 1'b0;
`endif
  assign WReady      = cnt < CW'(FIFO_DEPTH);
  assign pop         = cnt != '0 && (state == IDLE || k == 2'd3);
  assign Busy        = cnt != '0 || state == WRITE;
  assign unused_addr = ^WAddr[31:ADDR_W];
  // FIFO storage; contents need no reset since occupancy gates every read
  always_ff @(posedge CLK)
    if (push) mem[wptr] <= {WAddr[ADDR_W-1:0], WData};
  // FIFO pointers and occupancy
  always_ff @(posedge CLK or negedge Reset)
    if (!Reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      wptr <= push ? (wptr == LAST ? '0 : wptr + 1'b1) : wptr;
      rptr <= pop ? (rptr == LAST ? '0 : rptr + 1'b1) : rptr;
      cnt  <= cnt + CW'(push) - CW'(pop);
    end
  // sequencer: load a word on pop, then walk the four byte slots
  always_ff @(posedge CLK or negedge Reset)
    if (!Reset) begin
      state <= IDLE;
      k     <= '0;
      a     <= '0;
      w     <= '0;
    end else if (pop) begin
      state  <= WRITE;
      k      <= '0;
      {a, w} <= mem[rptr];
    end else if (state == WRITE) begin
      k     <= k + 2'd1;
      state <= k == 2'd3 ? IDLE : WRITE;
    end
  // registered byte-write port, one cycle behind the sequencer
  always_ff @(posedge CLK or negedge Reset)
    if (!Reset) begin
      MemWE   <= 1'b0;
      MemAddr <= '0;
      MemByte <= '0;
    end else begin
      MemWE <= state == WRITE;
      if (state == WRITE) begin
        MemAddr <= a + ADDR_W'(k);
        MemByte <= k == 2'd0 ? w[31:24] : k == 2'd1 ? w[23:16] : k == 2'd2 ? w[15:8] : w[7:0];
      end
    end
endmodule

// File: tb/tb_imem_writer.sv
// tb_imem_writer: directed checks of latency, byte order, back-to-back, wrap, reset abort and misalignment
module tb_imem_writer;
  logic        CLK = 1'b0, Reset, WValid, WReady, MemWE, Busy, Err;
  logic [31:0] WAddr, WData;
  logic [6:0]  MemAddr;
  logic [7:0]  MemByte;
  logic [15:0] log_q [$];
  int          errors = 0, checks = 0, run = 0, maxrun = 0;
  logic [31:0] b2b_d [3] = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
  logic [31:0] b2b_a [3] = '{32'h20, 32'h24, 32'h28};
  imem_writer dut (
    .CLK(CLK), .Reset(Reset), .WValid(WValid), .WReady(WReady), .WAddr(WAddr), .WData(WData),
    .MemWE(MemWE), .MemAddr(MemAddr), .MemByte(MemByte), .Busy(Busy), .Err(Err)
  );
  always #5 CLK = ~CLK;
  // record every byte write and the longest unbroken write burst
  always @(negedge CLK) begin
    if (MemWE) begin
      log_q.push_back({1'b0, MemAddr, MemByte});
      run = run + 1;
      if (run > maxrun) maxrun = run;
    end else run = 0;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // offer one word starting at a negedge; returns at the negedge after acceptance
  task automatic send(input logic [31:0] ad, input logic [31:0] dt);
    WValid = 1'b1;
    WAddr  = ad;
    WData  = dt;
    for (int i = 0; i < 50 && !WReady; i++) @(negedge CLK);
    if (!WReady) chk("send_timeout", {31'b0, WReady}, 32'd1);
    @(negedge CLK);
    WValid = 1'b0;
  endtask
  task automatic chk_log(input string tag, input int idx, input logic [15:0] exp);
    chk(tag, idx < log_q.size() ? {16'b0, log_q[idx]} : 32'hDEAD, {16'b0, exp});
  endtask
  initial begin
    Reset = 1'b0; WValid = 1'b0; WAddr = '0; WData = '0;
    @(negedge CLK);
    chk("rst_wready", {31'b0, WReady}, 32'd1);
    chk("rst_busy", {31'b0, Busy}, 32'd0);
    chk("rst_memwe", {31'b0, MemWE}, 32'd0);
    chk("rst_addr", {25'b0, MemAddr}, 32'd0);
    chk("rst_byte", {24'b0, MemByte}, 32'd0);
    chk("rst_err", {31'b0, Err}, 32'd0);
    Reset = 1'b1;
    send(32'h10, 32'h8C220004);
    chk("s_busy_push", {31'b0, Busy}, 32'd1);
    chk("s_we_early0", {31'b0, MemWE}, 32'd0);
    @(negedge CLK);
    chk("s_we_early1", {31'b0, MemWE}, 32'd0);
    @(negedge CLK);
    chk("s_we_first", {31'b0, MemWE}, 32'd1);
    repeat (4) @(negedge CLK);
    chk("s_we_done", {31'b0, MemWE}, 32'd0);
    chk("s_busy_done", {31'b0, Busy}, 32'd0);
    chk("s_addr_hold", {25'b0, MemAddr}, 32'h13);
    chk("s_byte_hold", {24'b0, MemByte}, 32'h04);
    chk("s_count", log_q.size(), 32'd4);
    chk_log("s_b0", 0, 16'h108C);
    chk_log("s_b1", 1, 16'h1122);
    chk_log("s_b2", 2, 16'h1200);
    chk_log("s_b3", 3, 16'h1304);
    log_q.delete(); maxrun = 0;
    for (int j = 0; j < 3; j++) send(b2b_a[j], b2b_d[j]);
    chk("b_wready_full", {31'b0, WReady}, 32'd0);
    chk("b_busy", {31'b0, Busy}, 32'd1);
    repeat (20) @(negedge CLK);
    chk("b_count", log_q.size(), 32'd12);
    chk("b_run", maxrun, 32'd12);
    for (int j = 0; j < 3; j++)
      for (int b = 0; b < 4; b++)
        chk_log($sformatf("b_w%0d_b%0d", j, b), 4 * j + b, {b2b_a[j][7:0] + 8'(b), 8'(b2b_d[j] >> (24 - 8 * b))});
    log_q.delete();
    send(32'h7E, 32'hAABBCCDD);
    repeat (10) @(negedge CLK);
    chk("w_count", log_q.size(), 32'd4);
    chk_log("w_b0", 0, 16'h7EAA);
    chk_log("w_b1", 1, 16'h7FBB);
    chk_log("w_b2", 2, 16'h00CC);
    chk_log("w_b3", 3, 16'h01DD);
    log_q.delete();
    send(32'h40, 32'h01020304);
    send(32'h44, 32'h05060708);
    @(negedge CLK);
    @(negedge CLK);
    #2 Reset = 1'b0;
    #1;
    chk("r_memwe", {31'b0, MemWE}, 32'd0);
    chk("r_busy", {31'b0, Busy}, 32'd0);
    chk("r_wready", {31'b0, WReady}, 32'd1);
    repeat (2) @(negedge CLK);
    Reset = 1'b1;
    repeat (15) @(negedge CLK);
    chk("r_count", log_q.size(), 32'd2);
    chk_log("r_b0", 0, 16'h4001);
    chk_log("r_b1", 1, 16'h4102);
    log_q.delete();
    send(32'h05, 32'h12345678);
`ifdef IMEM_WR_ALIGN_CHECK_EN
    chk("m_err_pulse", {31'b0, Err}, 32'd1);
    @(negedge CLK);
    chk("m_err_clear", {31'b0, Err}, 32'd0);
    repeat (10) @(negedge CLK);
    chk("m_count", log_q.size(), 32'd0);
    chk("m_busy", {31'b0, Busy}, 32'd0);
`else
    chk("m_err", {31'b0, Err}, 32'd0);
    repeat (10) @(negedge CLK);
    chk("m_count", log_q.size(), 32'd4);
    chk_log("m_b0", 0, 16'h0512);
    chk_log("m_b1", 1, 16'h0634);
    chk_log("m_b2", 2, 16'h0756);
    chk_log("m_b3", 3, 16'h0878);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
